// File: rtl/axi_user_pkg.sv
// Shared types and defaults for the AXI user-interface arbiter between
// the I-cache (port 0) and D-cache (port 1) engines.
package axi_user_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_XFER  = 2'd2
   } arb_state_e;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
   localparam int LEN_W_DEF  = 8;

   // With both ports pending, round-robin takes the port that did not go last;
   // fixed priority always favours the D-cache.
   function automatic logic pick_winner(input logic pend0, input logic pend1,
                                        input logic rr_en, input logic last);
      logic win;
      if (pend0 && pend1) begin
         win = rr_en ? ~last : PORT_D;
      end else if (pend1) begin
         win = PORT_D;
      end else begin
         win = PORT_I;
      end
      return win;
   endfunction

endpackage

// File: rtl/axi_user_arbiter_if.sv
// One AXI user-interface link; the requester side drives start/request/write
// fields, the responder side drives handshakes, read data, done and busy.
interface axi_user_arbiter_if
   import axi_user_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) ();

   logic              start;
   logic              rw;
   logic [ADDR_W-1:0] addr;
   logic [LEN_W-1:0]  len;
   logic [DATA_W-1:0] wdata;
   logic              wvalid;
   logic              wready;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;
   logic              done;
   logic              busy;

   modport master (
      output start, rw, addr, len, wdata, wvalid,
      input  wready, rdata, rvalid, done, busy
   );

   modport slave (
      input  start, rw, addr, len, wdata, wvalid,
      output wready, rdata, rvalid, done, busy
   );

endinterface

// File: rtl/axi_req_slot.sv
// Per-port request holder: captures a start pulse and its fields while idle,
// holds them until the owning transfer completes.
module axi_req_slot
   import axi_user_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [LEN_W-1:0]  len,
   input  logic              clr,
   output logic              pend,
   output logic              rw_q,
   output logic [ADDR_W-1:0] addr_q,
   output logic [LEN_W-1:0]  len_q
);

   logic              pend_r;
   logic              rw_r;
   logic [ADDR_W-1:0] addr_r;
   logic [LEN_W-1:0]  len_r;

   // Pending flag and latched request; a start while already pending is dropped.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pend_r <= 1'b0;
         rw_r   <= 1'b0;
         addr_r <= {ADDR_W{1'b0}};
         len_r  <= {LEN_W{1'b0}};
      end else if (clr) begin
         pend_r <= 1'b0;
      end else if (start && !pend_r) begin
         pend_r <= 1'b1;
         rw_r   <= rw;
         addr_r <= addr;
         len_r  <= len;
      end else begin
         pend_r <= pend_r;
      end
   end

   assign pend   = pend_r;
   assign rw_q   = rw_r;
   assign addr_q = addr_r;
   assign len_q  = len_r;

endmodule

// File: rtl/axi_user_arbiter.sv
// Arbitrates the single downstream AXI user interface between the I-cache
// (s0) and D-cache (s1), replaying the winner's request and routing its beats.
module axi_user_arbiter
   import axi_user_pkg::*;
#(
   parameter bit RR_EN  = 1'b1,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic               clk,
   input  logic               resetn,
   axi_user_arbiter_if.slave  s0,
   axi_user_arbiter_if.slave  s1,
   axi_user_arbiter_if.master m
);

   arb_state_e state_r, state_s;
   logic       owner_r, owner_s;
   logic       last_r, last_s;

   logic              pend0_s, pend1_s;
   logic              rw0_s, rw1_s;
   logic [ADDR_W-1:0] addr0_s, addr1_s;
   logic [LEN_W-1:0]  len0_s, len1_s;
   logic              fin_s, clr0_s, clr1_s;

   logic              m_start_s, m_rw_s, m_wvalid_s;
   logic [ADDR_W-1:0] m_addr_s;
   logic [LEN_W-1:0]  m_len_s;
   logic [DATA_W-1:0] m_wdata_s;
   logic              s0_wready_s, s0_rvalid_s, s0_done_s;
   logic              s1_wready_s, s1_rvalid_s, s1_done_s;

   // Downstream completion only counts while a transfer is in flight.
   assign fin_s  = (state_r == ST_XFER) && m.done;
   assign clr0_s = fin_s && (owner_r == PORT_I);
   assign clr1_s = fin_s && (owner_r == PORT_D);

   axi_req_slot #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_slot0 (
      .clk(clk), .resetn(resetn),
      .start(s0.start), .rw(s0.rw), .addr(s0.addr), .len(s0.len), .clr(clr0_s),
      .pend(pend0_s), .rw_q(rw0_s), .addr_q(addr0_s), .len_q(len0_s)
   );

   axi_req_slot #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_slot1 (
      .clk(clk), .resetn(resetn),
      .start(s1.start), .rw(s1.rw), .addr(s1.addr), .len(s1.len), .clr(clr1_s),
      .pend(pend1_s), .rw_q(rw1_s), .addr_q(addr1_s), .len_q(len1_s)
   );

   // Arbiter state, current owner and last-served port.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= ST_IDLE;
         owner_r <= PORT_I;
         last_r  <= PORT_I;
      end else begin
         state_r <= state_s;
         owner_r <= owner_s;
         last_r  <= last_s;
      end
   end

   // Next-state: grant only when the downstream master is free.
   always_comb begin
      state_s = state_r;
      owner_s = owner_r;
      last_s  = last_r;
      case (state_r)
         ST_IDLE: begin
            if ((pend0_s || pend1_s) && !m.busy) begin
               owner_s = pick_winner(pend0_s, pend1_s, RR_EN, last_r);
               state_s = ST_ISSUE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_s = ST_XFER;
         end
         ST_XFER: begin
            if (m.done) begin
               last_s  = owner_r;
               state_s = ST_IDLE;
            end else begin
               state_s = ST_XFER;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Request replay and per-owner routing; the non-owner sees no handshakes.
   always_comb begin
      m_start_s   = 1'b0;
      m_rw_s      = 1'b0;
      m_addr_s    = {ADDR_W{1'b0}};
      m_len_s     = {LEN_W{1'b0}};
      m_wdata_s   = {DATA_W{1'b0}};
      m_wvalid_s  = 1'b0;
      s0_wready_s = 1'b0;
      s0_rvalid_s = 1'b0;
      s0_done_s   = 1'b0;
      s1_wready_s = 1'b0;
      s1_rvalid_s = 1'b0;
      s1_done_s   = 1'b0;
      if (state_r == ST_IDLE) begin
         m_start_s = 1'b0;
      end else begin
         m_start_s = (state_r == ST_ISSUE);
         m_rw_s    = (owner_r == PORT_D) ? rw1_s   : rw0_s;
         m_addr_s  = (owner_r == PORT_D) ? addr1_s : addr0_s;
         m_len_s   = (owner_r == PORT_D) ? len1_s  : len0_s;
      end
      if (state_r == ST_XFER) begin
         m_wdata_s  = (owner_r == PORT_D) ? s1.wdata  : s0.wdata;
         m_wvalid_s = (owner_r == PORT_D) ? s1.wvalid : s0.wvalid;
         if (owner_r == PORT_D) begin
            s1_wready_s = m.wready;
            s1_rvalid_s = m.rvalid;
            s1_done_s   = m.done;
         end else begin
            s0_wready_s = m.wready;
            s0_rvalid_s = m.rvalid;
            s0_done_s   = m.done;
         end
      end else begin
         m_wvalid_s = 1'b0;
      end
   end

   assign m.start  = m_start_s;
   assign m.rw     = m_rw_s;
   assign m.addr   = m_addr_s;
   assign m.len    = m_len_s;
   assign m.wdata  = m_wdata_s;
   assign m.wvalid = m_wvalid_s;

   assign s0.wready = s0_wready_s;
   assign s0.rvalid = s0_rvalid_s;
   assign s0.done   = s0_done_s;
   assign s0.busy   = pend0_s;
   assign s0.rdata  = m.rdata;

   assign s1.wready = s1_wready_s;
   assign s1.rvalid = s1_rvalid_s;
   assign s1.done   = s1_done_s;
   assign s1.busy   = pend1_s;
   assign s1.rdata  = m.rdata;

endmodule

// File: tb/tb_axi_user_arbiter.sv
// Directed bench: round-robin arbiter as the main DUT, a fixed-priority copy
// fed the same stimulus for the priority-order scenario.
module tb_axi_user_arbiter;

   logic clk;
   logic resetn;
   int   chk_cnt = 0;
   int   err_cnt = 0;
   int   n;

   axi_user_arbiter_if s0_if ();
   axi_user_arbiter_if s1_if ();
   axi_user_arbiter_if m_if ();
   axi_user_arbiter_if s0f ();
   axi_user_arbiter_if s1f ();
   axi_user_arbiter_if mf ();

   axi_user_arbiter #(.RR_EN(1'b1)) dut_rr (
      .clk(clk), .resetn(resetn), .s0(s0_if), .s1(s1_if), .m(m_if)
   );

   axi_user_arbiter #(.RR_EN(1'b0)) dut_fp (
      .clk(clk), .resetn(resetn), .s0(s0f), .s1(s1f), .m(mf)
   );

   assign s0f.start  = s0_if.start;
   assign s0f.rw     = s0_if.rw;
   assign s0f.addr   = s0_if.addr;
   assign s0f.len    = s0_if.len;
   assign s0f.wdata  = s0_if.wdata;
   assign s0f.wvalid = s0_if.wvalid;
   assign s1f.start  = s1_if.start;
   assign s1f.rw     = s1_if.rw;
   assign s1f.addr   = s1_if.addr;
   assign s1f.len    = s1_if.len;
   assign s1f.wdata  = s1_if.wdata;
   assign s1f.wvalid = s1_if.wvalid;
   assign mf.wready  = m_if.wready;
   assign mf.rdata   = m_if.rdata;
   assign mf.rvalid  = m_if.rvalid;
   assign mf.done    = m_if.done;
   assign mf.busy    = m_if.busy;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      s0_if.start = 1'b0; s0_if.rw = 1'b0; s0_if.addr = 32'h0; s0_if.len = 8'h0;
      s0_if.wdata = 32'h0; s0_if.wvalid = 1'b0;
      s1_if.start = 1'b0; s1_if.rw = 1'b0; s1_if.addr = 32'h0; s1_if.len = 8'h0;
      s1_if.wdata = 32'h0; s1_if.wvalid = 1'b0;
      m_if.wready = 1'b0; m_if.rdata = 32'h0; m_if.rvalid = 1'b0;
      m_if.done = 1'b0; m_if.busy = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      clear_inputs();
      tick();
      tick();
      resetn = 1'b1;
      tick();
   endtask

   // Wait for m_start, check the replayed read request, stream len+1 beats, finish.
   task automatic serve(input logic port, input logic [31:0] addr, input logic [7:0] len,
                        output int waited);
      waited = 0;
      while (m_if.start !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      check_eq("start_seen", m_if.start, 1'b1);
      check_eq("req_rw", m_if.rw, 1'b1);
      check_eq("req_addr", m_if.addr, addr);
      check_eq("req_len", m_if.len, len);
      m_if.busy = 1'b1;
      tick();
      for (int b = 0; b <= int'(len); b++) begin
         m_if.rvalid = 1'b1;
         m_if.rdata  = 32'hA5A5_0000 + b;
         #1;
         check_eq("rvalid_own", port ? s1_if.rvalid : s0_if.rvalid, 1'b1);
         check_eq("rvalid_other", port ? s0_if.rvalid : s1_if.rvalid, 1'b0);
         check_eq("rdata_own", port ? s1_if.rdata : s0_if.rdata, 32'hA5A5_0000 + b);
         tick();
      end
      m_if.rvalid = 1'b0;
      m_if.done   = 1'b1;
      #1;
      check_eq("done_own", port ? s1_if.done : s0_if.done, 1'b1);
      check_eq("done_other", port ? s0_if.done : s1_if.done, 1'b0);
      tick();
      m_if.done = 1'b0;
      m_if.busy = 1'b0;
      check_eq("busy_clr", port ? s1_if.busy : s0_if.busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish before timeout");
      $fatal(1);
   end

   initial begin
      do_reset();
      check_eq("rst_m_start", m_if.start, 1'b0);
      check_eq("rst_m_addr", m_if.addr, 32'h0);
      check_eq("rst_m_wvalid", m_if.wvalid, 1'b0);
      check_eq("rst_s0_busy", s0_if.busy, 1'b0);
      check_eq("rst_s1_busy", s1_if.busy, 1'b0);
      check_eq("rst_s1_done", s1_if.done, 1'b0);

      // Single D-cache read burst of 4 beats
      s1_if.rw = 1'b1; s1_if.addr = 32'h0000_1000; s1_if.len = 8'd3; s1_if.start = 1'b1;
      tick();
      s1_if.start = 1'b0;
      check_eq("t1_busy_c1", s1_if.busy, 1'b1);
      check_eq("t1_s0_idle", s0_if.busy, 1'b0);
      check_eq("t1_nostart_c1", m_if.start, 1'b0);
      serve(1'b1, 32'h0000_1000, 8'd3, n);
      check_eq("t1_latency", n, 1);

      // Simultaneous requests: D-cache first, I-cache two cycles after done
      do_reset();
      s0_if.rw = 1'b1; s0_if.addr = 32'h0000_3000; s0_if.len = 8'd0; s0_if.start = 1'b1;
      s1_if.rw = 1'b1; s1_if.addr = 32'h0000_4000; s1_if.len = 8'd1; s1_if.start = 1'b1;
      tick();
      s0_if.start = 1'b0;
      s1_if.start = 1'b0;
      serve(1'b1, 32'h0000_4000, 8'd1, n);
      check_eq("t2_first_lat", n, 1);
      serve(1'b0, 32'h0000_3000, 8'd0, n);
      check_eq("t2_second_lat", n, 1);

      // Continuous requests from both: RR alternates, fixed priority keeps port 1
      do_reset();
      s0_if.rw = 1'b1; s0_if.addr = 32'h0000_5000; s0_if.len = 8'd0; s0_if.start = 1'b1;
      s1_if.rw = 1'b1; s1_if.addr = 32'h0000_6000; s1_if.len = 8'd0; s1_if.start = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (m_if.start !== 1'b1 && n < 20) begin
            tick();
            n++;
         end
         check_eq("t3_start", m_if.start, 1'b1);
         check_eq("t3_rr_addr", m_if.addr, (k % 2 == 0) ? 32'h0000_6000 : 32'h0000_5000);
         check_eq("t3_fp_start", mf.start, 1'b1);
         check_eq("t3_fp_addr", mf.addr, 32'h0000_6000);
         m_if.busy = 1'b1;
         tick();
         m_if.done = 1'b1;
         tick();
         m_if.done = 1'b0;
         tick();
         m_if.busy = 1'b0;
      end
      check_eq("t3_fp_s0_waiting", s0f.busy, 1'b1);
      s0_if.start = 1'b0;
      s1_if.start = 1'b0;

      // I-cache write burst of two beats with a wready stall
      do_reset();
      s0_if.rw = 1'b0; s0_if.addr = 32'h0000_2000; s0_if.len = 8'd1; s0_if.start = 1'b1;
      tick();
      s0_if.start = 1'b0;
      tick();
      check_eq("t4_start", m_if.start, 1'b1);
      check_eq("t4_rw", m_if.rw, 1'b0);
      check_eq("t4_addr", m_if.addr, 32'h0000_2000);
      m_if.busy = 1'b1;
      tick();
      s0_if.wdata = 32'hDEAD_BEEF; s0_if.wvalid = 1'b1; m_if.wready = 1'b1;
      #1;
      check_eq("t4_wdata0", m_if.wdata, 32'hDEAD_BEEF);
      check_eq("t4_wvalid0", m_if.wvalid, 1'b1);
      check_eq("t4_s0_wready0", s0_if.wready, 1'b1);
      check_eq("t4_s1_wready0", s1_if.wready, 1'b0);
      tick();
      s0_if.wdata = 32'h1234_5678; m_if.wready = 1'b0;
      #1;
      check_eq("t4_s0_wready_stall", s0_if.wready, 1'b0);
      tick();
      m_if.wready = 1'b1;
      #1;
      check_eq("t4_wdata1", m_if.wdata, 32'h1234_5678);
      check_eq("t4_s0_wready1", s0_if.wready, 1'b1);
      check_eq("t4_s1_wready1", s1_if.wready, 1'b0);
      tick();
      s0_if.wvalid = 1'b0; m_if.wready = 1'b0; m_if.done = 1'b1;
      #1;
      check_eq("t4_done", s0_if.done, 1'b1);
      tick();
      m_if.done = 1'b0; m_if.busy = 1'b0;
      check_eq("t4_busy_clr", s0_if.busy, 1'b0);
      check_eq("t4_wvalid_idle", m_if.wvalid, 1'b0);

      // Downstream busy holds off the grant
      do_reset();
      m_if.busy = 1'b1;
      s1_if.rw = 1'b1; s1_if.addr = 32'h0000_A000; s1_if.len = 8'd0; s1_if.start = 1'b1;
      tick();
      s1_if.start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("t5_held", m_if.start, 1'b0);
      end
      m_if.busy = 1'b0;
      tick();
      check_eq("t5_start", m_if.start, 1'b1);
      check_eq("t5_addr", m_if.addr, 32'h0000_A000);
      m_if.busy = 1'b1;
      tick();
      m_if.done = 1'b1;
      tick();
      m_if.done = 1'b0; m_if.busy = 1'b0;

      // Reset mid-transfer, then normal operation and a dropped stray start
      do_reset();
      s0_if.rw = 1'b1; s0_if.addr = 32'h0000_7000; s0_if.len = 8'd3; s0_if.start = 1'b1;
      tick();
      s0_if.start = 1'b0;
      tick();
      m_if.busy = 1'b1;
      tick();
      m_if.rvalid = 1'b1;
      #1;
      check_eq("t6_rvalid_pre", s0_if.rvalid, 1'b1);
      resetn = 1'b0;
      #1;
      check_eq("t6_rst_rvalid", s0_if.rvalid, 1'b0);
      check_eq("t6_rst_addr", m_if.addr, 32'h0);
      check_eq("t6_rst_rw", m_if.rw, 1'b0);
      check_eq("t6_rst_busy", s0_if.busy, 1'b0);
      m_if.rvalid = 1'b0; m_if.busy = 1'b0;
      tick();
      resetn = 1'b1;
      tick();
      s0_if.addr = 32'h0000_7100; s0_if.len = 8'd0; s0_if.start = 1'b1;
      tick();
      s0_if.start = 1'b0;
      s1_if.rw = 1'b1; s1_if.addr = 32'h0000_8000; s1_if.len = 8'd0; s1_if.start = 1'b1;
      tick();
      check_eq("t6_start", m_if.start, 1'b1);
      check_eq("t6_addr", m_if.addr, 32'h0000_7100);
      check_eq("t6_s1_busy", s1_if.busy, 1'b1);
      s1_if.addr = 32'h0000_9000;
      m_if.busy = 1'b1;
      tick();
      s1_if.start = 1'b0;
      m_if.done = 1'b1;
      #1;
      check_eq("t6_done", s0_if.done, 1'b1);
      tick();
      m_if.done = 1'b0; m_if.busy = 1'b0;
      tick();
      check_eq("t6_s1_start", m_if.start, 1'b1);
      check_eq("t6_s1_addr", m_if.addr, 32'h0000_8000);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
